ex_mem_pipe: RTL and testbench
==============================

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SIZE, 32, datapath width in bits; multiple of 8, >=16.
REQ-002 ADDR_SIZE, 5, register-file write-address width.
REQ-003 S_WB, 2, write-back control bundle width.
REQ-004 S_M, 3, memory control bundle width.
REQ-005 CNT_W, 16, bubble-counter width.
REQ-006 clk  input  1  single clock; all state changes on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 stall  input  1  hold all stage registers.
REQ-009 flush  input  1  insert bubble.
REQ-010 valid_in  input  1  EX stage holds a real instruction.
REQ-011 WB  input  S_WB  write-back control.
REQ-012 M  input  S_M  memory control.
REQ-013 zero_in  input  1  ALU zero flag.
REQ-014 data_in  input  SIZE  ALU result.
REQ-015 data_in2  input  SIZE  store data (rt value).
REQ-016 AWriteMem_in  input  SIZE  memory byte address.
REQ-017 AWriteReg_in  input  ADDR_SIZE  destination register.
REQ-018 is_byte_in  input  1  byte-size access.
REQ-019 WB_out, M_out, zero_out, data_out, AWriteMem, AWriteReg, is_byte_out  output  same widths as inputs  registered copies.
REQ-020 data_out2  output  SIZE  registered store data, byte-replicated when is_byte.
REQ-021 valid_out  output  1  MEM stage holds a real instruction.
REQ-022 be_out  output  SIZE/8  registered byte-lane enables.
REQ-023 bubble_cnt  output  CNT_W  saturating count of bubble/stall cycles.

Function
REQ-024 Priority per cycle SHALL be: rst > flush > stall > load.
REQ-025 Load (no rst/flush/stall): every output register SHALL take its input-derived value at the next posedge; latency exactly 1 cycle.
REQ-026 zero_out SHALL be registered with the other fields (the flag is part of the bundle, not dropped).
REQ-027 valid_out SHALL load valid_in; when valid_in=0, WB_out and M_out SHALL load 0.
REQ-028 Stall: all outputs except bubble_cnt SHALL hold their current values.
REQ-029 Flush: WB_out, M_out, be_out, valid_out SHALL become 0; data/address/zero/is_byte fields SHALL hold; flush with stall behaves as flush.
REQ-030 Lane index SHALL be AWriteMem_in[log2(SIZE/8)-1:0], little-endian (lane 0 = bits 7:0).
REQ-031 is_byte_in=1: be_out SHALL be one-hot at the lane index; data_out2 SHALL be data_in2[7:0] replicated into every lane.
REQ-032 is_byte_in=0: be_out SHALL be all-ones; data_out2 SHALL equal data_in2 unmodified.
REQ-033 be_out SHALL be forced to 0 whenever the registered M_out or valid_out is 0 after load/flush.
REQ-034 bubble_cnt SHALL increment by 1 on each non-reset cycle with flush=1 or stall=1, and saturate at 2^CNT_W-1 (no wrap).
REQ-035 No combinational path from any input to any output.

Reset
REQ-036 With rst=1 at posedge, all outputs, including bubble_cnt, SHALL become 0 regardless of stall/flush.
REQ-037 Reset asserted mid-stall or mid-flush SHALL take effect at that posedge; first load occurs at the first posedge with rst=0.

Verification
REQ-038 Load: valid_in=1, WB=2'b11, M=3'b010, data_in=0x1234_5678, AWriteReg_in=5'd9, zero_in=1 -> next cycle same values on outputs, valid_out=1, zero_out=1, be_out=4'hF.
REQ-039 Byte store: is_byte_in=1, AWriteMem_in=0x0000_0102, data_in2=0xAABB_CCDD -> be_out=4'b0100, data_out2=0xDDDD_DDDD.
REQ-040 Stall 3 cycles then release with new inputs -> outputs frozen for 3 cycles, new values 1 cycle after release, bubble_cnt=3.
REQ-041 flush and stall together with M=3'b111 -> M_out=0, WB_out=0, valid_out=0, be_out=0, data_out unchanged, bubble_cnt+1.
REQ-042 CNT_W=2, stall held 6 cycles -> bubble_cnt 1,2,3,3,3,3; rst=1 with stall=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register. It carries the control, data and address fields and the byte-lane enables.
// It also keeps a saturating counter of the cycles spent in a bubble or a stall.
module ex_mem_pipe #(
    parameter int SIZE      = 32,
    parameter int ADDR_SIZE = 5,
    parameter int S_WB      = 2,
    parameter int S_M       = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [S_WB-1:0]      WB,
    input  logic [S_M-1:0]       M,
    input  logic                 zero_in,
    input  logic [SIZE-1:0]      data_in,
    input  logic [SIZE-1:0]      data_in2,
    input  logic [SIZE-1:0]      AWriteMem_in,
    input  logic [ADDR_SIZE-1:0] AWriteReg_in,
    input  logic                 is_byte_in,
    output logic [S_WB-1:0]      WB_out,
    output logic [S_M-1:0]       M_out,
    output logic                 zero_out,
    output logic [SIZE-1:0]      data_out,
    output logic [SIZE-1:0]      data_out2,
    output logic [SIZE-1:0]      AWriteMem,
    output logic [ADDR_SIZE-1:0] AWriteReg,
    output logic                 is_byte_out,
    output logic                 valid_out,
    output logic [SIZE/8-1:0]    be_out,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam int LANES  = SIZE / 8;
    localparam int LANE_W = $clog2(LANES);

    logic [S_WB-1:0]      r_wb;
    logic [S_M-1:0]       r_m;
    logic                 r_zero;
    logic [SIZE-1:0]      r_data;
    logic [SIZE-1:0]      r_data2;
    logic [SIZE-1:0]      r_awm;
    logic [ADDR_SIZE-1:0] r_awr;
    logic                 r_is_byte;
    logic                 r_valid;
    logic [LANES-1:0]     r_be;
    logic [CNT_W-1:0]     r_bubble_cnt;

    logic [LANE_W-1:0]    w_lane;
    logic [LANES-1:0]     w_be_load;
    logic [SIZE-1:0]      w_data2_load;

    // A bubble, or an instruction with no memory control, must never enable a byte lane.
    // NOTE: every always_comb output gets a default first, so no path through the block can leave a latch.
    always_comb begin
        w_lane       = AWriteMem_in[LANE_W-1:0];
        w_be_load    = '0;
        w_data2_load = data_in2;
        if (is_byte_in) begin
            w_data2_load = {LANES{data_in2[7:0]}};
        end
        if (valid_in && (|M)) begin
            if (is_byte_in) begin
                w_be_load[w_lane] = 1'b1;
            end else begin
                w_be_load = '1;
            end
        end
    end

    // Priority is rst > flush > stall > load. A stall holds every field because no branch assigns it.
    // NOTE: the state registers use non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb      <= '0;
            r_m       <= '0;
            r_zero    <= 1'b0;
            r_data    <= '0;
            r_data2   <= '0;
            r_awm     <= '0;
            r_awr     <= '0;
            r_is_byte <= 1'b0;
            r_valid   <= 1'b0;
            r_be      <= '0;
        end else if (flush) begin
            r_wb    <= '0;
            r_m     <= '0;
            r_valid <= 1'b0;
            r_be    <= '0;
        end else if (!stall) begin
            r_wb      <= valid_in ? WB : '0;
            r_m       <= valid_in ? M : '0;
            r_zero    <= zero_in;
            r_data    <= data_in;
            r_data2   <= w_data2_load;
            r_awm     <= AWriteMem_in;
            r_awr     <= AWriteReg_in;
            r_is_byte <= is_byte_in;
            r_valid   <= valid_in;
            r_be      <= w_be_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if ((flush || stall) && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign WB_out      = r_wb;
    assign M_out       = r_m;
    assign zero_out    = r_zero;
    assign data_out    = r_data;
    assign data_out2   = r_data2;
    assign AWriteMem   = r_awm;
    assign AWriteReg   = r_awr;
    assign is_byte_out = r_is_byte;
    assign valid_out   = r_valid;
    assign be_out      = r_be;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed scenarios, then random traffic checked against a behavioural model.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_ex_mem_pipe;

    localparam int SIZE = 32;
    localparam int AS   = 5;

    logic            clk = 1'b0;
    logic            rst, stall, flush, valid_in, zero_in, is_byte_in;
    logic [1:0]      WB;
    logic [2:0]      M;
    logic [SIZE-1:0] data_in, data_in2, AWriteMem_in;
    logic [AS-1:0]   AWriteReg_in;

    logic [1:0]      WB_out;
    logic [2:0]      M_out;
    logic            zero_out, is_byte_out, valid_out;
    logic [SIZE-1:0] data_out, data_out2, AWriteMem;
    logic [AS-1:0]   AWriteReg;
    logic [3:0]      be_out;
    logic [15:0]     bubble_cnt;

    logic [1:0]      s_WB_out;
    logic [2:0]      s_M_out;
    logic            s_zero_out, s_is_byte_out, s_valid_out;
    logic [SIZE-1:0] s_data_out, s_data_out2, s_AWriteMem;
    logic [AS-1:0]   s_AWriteReg;
    logic [3:0]      s_be_out;
    logic [1:0]      s_bubble_cnt;

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .WB(WB), .M(M), .zero_in(zero_in), .data_in(data_in), .data_in2(data_in2),
        .AWriteMem_in(AWriteMem_in), .AWriteReg_in(AWriteReg_in), .is_byte_in(is_byte_in),
        .WB_out(WB_out), .M_out(M_out), .zero_out(zero_out), .data_out(data_out),
        .data_out2(data_out2), .AWriteMem(AWriteMem), .AWriteReg(AWriteReg),
        .is_byte_out(is_byte_out), .valid_out(valid_out), .be_out(be_out),
        .bubble_cnt(bubble_cnt)
    );

    ex_mem_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .WB(WB), .M(M), .zero_in(zero_in), .data_in(data_in), .data_in2(data_in2),
        .AWriteMem_in(AWriteMem_in), .AWriteReg_in(AWriteReg_in), .is_byte_in(is_byte_in),
        .WB_out(s_WB_out), .M_out(s_M_out), .zero_out(s_zero_out), .data_out(s_data_out),
        .data_out2(s_data_out2), .AWriteMem(s_AWriteMem), .AWriteReg(s_AWriteReg),
        .is_byte_out(s_is_byte_out), .valid_out(s_valid_out), .be_out(s_be_out),
        .bubble_cnt(s_bubble_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of what the MEM stage should hold.
    logic [1:0]      m_wb;
    logic [2:0]      m_m;
    logic            m_zero, m_isb, m_valid;
    logic [SIZE-1:0] m_data, m_data2, m_awm;
    logic [AS-1:0]   m_awr;
    logic [3:0]      m_be;
    longint          m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    // Advance one clock, update the model from the inputs applied before the edge, then compare.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            {m_wb, m_m, m_zero, m_isb, m_valid, m_data, m_data2, m_awm, m_awr, m_be} = '0;
            m_cnt = 0;
        end else if (flush) begin
            m_wb = '0; m_m = '0; m_be = '0; m_valid = 1'b0;
            m_cnt++;
        end else if (stall) begin
            m_cnt++;
        end else begin
            m_valid = valid_in;
            m_wb    = valid_in ? WB : 2'b00;
            m_m     = valid_in ? M : 3'b000;
            m_zero  = zero_in;
            m_data  = data_in;
            m_awm   = AWriteMem_in;
            m_awr   = AWriteReg_in;
            m_isb   = is_byte_in;
            m_data2 = is_byte_in ? ({24'd0, data_in2[7:0]} * 32'h0101_0101) : data_in2;
            if (valid_in && M != 3'b000)
                m_be = is_byte_in ? 4'(1 << (AWriteMem_in % 4)) : 4'hF;
            else
                m_be = 4'h0;
        end
        #1;
        check("wb_out", 64'(WB_out), 64'(m_wb));
        check("m_out", 64'(M_out), 64'(m_m));
        check("zero_out", 64'(zero_out), 64'(m_zero));
        check("data_out", 64'(data_out), 64'(m_data));
        check("data_out2", 64'(data_out2), 64'(m_data2));
        check("awritemem", 64'(AWriteMem), 64'(m_awm));
        check("awritereg", 64'(AWriteReg), 64'(m_awr));
        check("is_byte_out", 64'(is_byte_out), 64'(m_isb));
        check("valid_out", 64'(valid_out), 64'(m_valid));
        check("be_out", 64'(be_out), 64'(m_be));
        check("bubble_cnt", 64'(bubble_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
        check("sat_bubble_cnt", 64'(s_bubble_cnt), 64'((m_cnt > 3) ? 3 : m_cnt));
        check("sat_data_out2", 64'(s_data_out2), 64'(m_data2));
        check("sat_be_out", 64'(s_be_out), 64'(m_be));
    endtask

    initial begin
        logic [1:0]  sat_seq [6];
        logic [31:0] held;
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        set_idle();
        valid_in = 1'b0; WB = '0; M = '0; zero_in = 1'b0; is_byte_in = 1'b0;
        data_in = '0; data_in2 = '0; AWriteMem_in = '0; AWriteReg_in = '0;

        // Reset state
        rst = 1'b1; step();
        check("reset_valid", 64'(valid_out), 64'd0);
        check("reset_cnt", 64'(bubble_cnt), 64'd0);

        // Full-word load
        set_idle();
        valid_in = 1'b1; WB = 2'b11; M = 3'b010; data_in = 32'h1234_5678;
        AWriteReg_in = 5'd9; zero_in = 1'b1; AWriteMem_in = 32'h0000_0100; data_in2 = 32'h0000_0055;
        step();
        check("load_data", 64'(data_out), 64'h1234_5678);
        check("load_wb", 64'(WB_out), 64'h3);
        check("load_m", 64'(M_out), 64'h2);
        check("load_awr", 64'(AWriteReg), 64'd9);
        check("load_zero", 64'(zero_out), 64'd1);
        check("load_valid", 64'(valid_out), 64'd1);
        check("load_be", 64'(be_out), 64'hF);

        // Byte store at lane 2
        is_byte_in = 1'b1; AWriteMem_in = 32'h0000_0102; data_in2 = 32'hAABB_CCDD;
        step();
        check("byte_be", 64'(be_out), 64'h4);
        check("byte_data2", 64'(data_out2), 64'hDDDD_DDDD);

        // Three-cycle stall, then release with new inputs
        rst = 1'b1; step();
        set_idle(); is_byte_in = 1'b0; data_in = 32'hCAFE_0001; step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'hDEAD_0000 + 32'(i);
            step();
            check("stall_hold", 64'(data_out), 64'hCAFE_0001);
        end
        stall = 1'b0; data_in = 32'hBEEF_0002; step();
        check("release_data", 64'(data_out), 64'hBEEF_0002);
        check("release_cnt", 64'(bubble_cnt), 64'd3);

        // Flush together with stall
        held = data_out;
        flush = 1'b1; stall = 1'b1; M = 3'b111; data_in = 32'h0BAD_0BAD; step();
        check("flush_m", 64'(M_out), 64'd0);
        check("flush_wb", 64'(WB_out), 64'd0);
        check("flush_valid", 64'(valid_out), 64'd0);
        check("flush_be", 64'(be_out), 64'd0);
        check("flush_data", 64'(data_out), 64'(held));
        check("flush_cnt", 64'(bubble_cnt), 64'd4);

        // Saturation of the 2-bit counter, then reset during a stall
        set_idle(); rst = 1'b1; step();
        set_idle(); stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("sat_seq", 64'(s_bubble_cnt), 64'(sat_seq[i]));
        end
        rst = 1'b1; step();
        check("rst_stall_valid", 64'(valid_out), 64'd0);
        check("rst_stall_data", 64'(data_out), 64'd0);
        check("rst_stall_cnt", 64'(bubble_cnt), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 49) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            valid_in     = ($urandom_range(0, 3) != 0);
            WB           = 2'($urandom);
            M            = 3'($urandom);
            zero_in      = 1'($urandom);
            is_byte_in   = 1'($urandom);
            data_in      = $urandom;
            data_in2     = $urandom;
            AWriteMem_in = $urandom;
            AWriteReg_in = 5'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
